// File: rtl/exec_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exec_muldiv_unit                                                |
// | Purpose  : Execute-stage multi-cycle multiply/divide unit owning the       |
// |            architectural HI/LO registers. Radix-2 shift-add multiply and   |
// |            restoring shift-subtract divide, one step per cycle, with its   |
// |            own operand forwarding muxes and a pipeline stall request.      |
// | Ports    : clk, rst            clock / synchronous active-high reset      |
// |            start_i, md_op_i    issue strobe and opcode                    |
// |                                (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)       |
// |            srcA_sel_i/srcB_sel_i  00 Mem/Wr fwd, 01 Ex/Mem fwd, 1x bus    |
// |            busA_i/busB_i, fwd_exmem_*_i, fwd_memwr_*_i  operand sources   |
// |            hi_we_i, lo_we_i, mt_data_i  MTHI/MTLO writes                  |
// |            flush_i             abort in-flight operation                  |
// |            busy_o, done_o, div_by_zero_o, stall_req_o  status             |
// |            hi_o, lo_o          architectural HI/LO                        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module exec_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      md_op_i,
  input  logic [1:0]      srcA_sel_i,
  input  logic [1:0]      srcB_sel_i,
  input  logic [XLEN-1:0] busA_i,
  input  logic [XLEN-1:0] busB_i,
  input  logic [XLEN-1:0] fwd_exmem_a_i,
  input  logic [XLEN-1:0] fwd_exmem_b_i,
  input  logic [XLEN-1:0] fwd_memwr_a_i,
  input  logic [XLEN-1:0] fwd_memwr_b_i,
  input  logic            hi_we_i,
  input  logic            lo_we_i,
  input  logic [XLEN-1:0] mt_data_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            div_by_zero_o,
  output logic            stall_req_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam logic [1:0]       S_IDLE   = 2'd0;
  localparam logic [1:0]       S_CALC   = 2'd1;
  localparam logic [1:0]       S_FIN    = 2'd2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  // State and datapath registers
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc holds {product_hi, multiplier/product_lo} for multiply and
  // {partial_remainder, dividend/quotient} for divide.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [XLEN-1:0]   opd_q, opd_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;
  logic              dzflag_q, dzflag_d;

  // Operand forwarding muxes
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;

  always_comb begin
    w_opa = busA_i;
    case (srcA_sel_i)
      2'b00:   w_opa = fwd_memwr_a_i;
      2'b01:   w_opa = fwd_exmem_a_i;
      default: w_opa = busA_i;
    endcase
  end

  always_comb begin
    w_opb = busB_i;
    case (srcB_sel_i)
      2'b00:   w_opb = fwd_memwr_b_i;
      2'b01:   w_opb = fwd_exmem_b_i;
      default: w_opb = busB_i;
    endcase
  end

  // Opcode decode and operand magnitude conversion
  logic            w_is_div;
  logic            w_is_signed;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_accept;
  logic            w_dz;

  assign w_is_div    = md_op_i[1];
  assign w_is_signed = ~md_op_i[0];
  assign w_sign_a    = w_is_signed & w_opa[XLEN-1];
  assign w_sign_b    = w_is_signed & w_opb[XLEN-1];
  // Most-negative stays most-negative after negation, which is also its
  // correct unsigned magnitude.
  assign w_mag_a     = w_sign_a ? -w_opa : w_opa;
  assign w_mag_b     = w_sign_b ? -w_opb : w_opb;
  assign w_accept    = (state_q == S_IDLE) & start_i & ~flush_i;
  assign w_dz        = w_is_div & (w_opb == '0);

  // Multiply step: conditionally add multiplicand to the upper half, then
  // shift the whole product right; the carry lands in the top bit.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                      (acc_q[0] ? {1'b0, opd_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // try subtracting the divisor, keep the difference only if non-negative.
  // The remainder is always below the divisor, so XLEN+1 bits suffice.
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_div_next;

  assign w_rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign w_diff     = w_rem_sh - {1'b0, opd_q};
  assign w_div_next = w_diff[XLEN]
                    ? {w_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {w_diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};

  // Final sign correction
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  assign w_prod_fix = neg_res_q ? -acc_q : acc_q;
  assign w_quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign w_rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    w_res_hi = w_prod_fix[2*XLEN-1:XLEN];
    w_res_lo = w_prod_fix[XLEN-1:0];
    if (dz_q) begin
      // acc was loaded with {raw dividend, all ones} at issue
      w_res_hi = acc_q[2*XLEN-1:XLEN];
      w_res_lo = acc_q[XLEN-1:0];
    end else if (is_div_q) begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quo_fix;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dzflag_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = mt_data_i;
        if (lo_we_i) lo_d = mt_data_i;
        if (w_accept) begin
          is_div_d  = w_is_div;
          neg_res_d = w_sign_a ^ w_sign_b;
          neg_rem_d = w_sign_a;
          dz_d      = w_dz;
          cnt_d     = CNT_INIT;
          if (w_dz) begin
            acc_d   = {w_opa, {XLEN{1'b1}}};
            opd_d   = '0;
            state_d = S_FIN;
          end else if (w_is_div) begin
            acc_d   = {{XLEN{1'b0}}, w_mag_a};
            opd_d   = w_mag_b;
            state_d = S_CALC;
          end else begin
            acc_d   = {{XLEN{1'b0}}, w_mag_b};
            opd_d   = w_mag_a;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        // MT writes land now but are replaced by the result at FIN.
        if (hi_we_i) hi_d = mt_data_i;
        if (lo_we_i) lo_d = mt_data_i;
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? w_div_next : w_mul_next;
          cnt_d = cnt_q - CNT_LAST;
          if (cnt_q == CNT_LAST) state_d = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          hi_d     = w_res_hi;
          lo_d     = w_res_lo;
          done_d   = 1'b1;
          dzflag_d = dz_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dzflag_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dzflag_q  <= dzflag_d;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign stall_req_o   = busy_o | (start_i & ~flush_i);
  assign done_o        = done_q;
  assign div_by_zero_o = dzflag_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;

endmodule
`default_nettype wire

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
- Parametrised execute-stage extension: multi-cycle multiply/divide datapath writing architectural HI/LO registers.
- Contains its own operand forwarding muxes.
- Sits beside the single-cycle ALU in Ex and stalls the pipeline through stall_req while an operation is in flight.
- Supports signed/unsigned MULT and DIV, MTHI/MTLO writes, and a pipeline flush abort.

Parameters:
- XLEN, 32, operand/HI/LO width (≥ 4).
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  issue MD op; sampled only when busy=0.
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srcA_sel  in  2  00 fwd_memwr_a, 01 fwd_exmem_a, 10/11 busA.
- srcB_sel  in  2  00 fwd_memwr_b, 01 fwd_exmem_b, 10/11 busB.
- busA, busB  in  XLEN  register-file operands.
- fwd_exmem_a, fwd_exmem_b  in  XLEN  Ex/Mem forwarded data.
- fwd_memwr_a, fwd_memwr_b  in  XLEN  Mem/Wr forwarded data.
- hi_we, lo_we  in  1  MTHI/MTLO write enables.
- mt_data  in  XLEN  MTHI/MTLO data (post-forwarding, from Ex).
- flush  in  1  abort in-flight op.
- busy  out  1  op in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  pulses with done when divisor was 0.
- stall_req  out  1  combinational busy | (start & ~flush).
- hi, lo  out  XLEN  architectural HI/LO.

Behaviour:
- Reset: state=IDLE, hi=lo=0, busy=done=div_by_zero=0, counter=0. Reset overrides all inputs, including mid-operation.
- Operand muxes: opA/opB are selected combinationally per srcA_sel/srcB_sel and latched on the edge where start=1 & IDLE & ~flush.
- Signed ops:
  - Latch operand magnitudes plus result-sign (MULT: signA^signB) and remainder-sign (DIV: signA).
  - Unsigned ops use raw values.
- States:
  - IDLE: start accepted → CALC (counter=XLEN). For DIV/DIVU with opB==0 → FIN directly.
  - CALC: one radix-2 step per cycle, counter decrements. Multiply: shift-add into a 2·XLEN product. Divide: restoring shift-subtract. At counter==1 → FIN.
  - FIN: apply sign correction (two's complement), write HI/LO on the edge, set done → IDLE.
- Timing (start accepted at edge ending cycle t):
  - busy=1 cycles t+1..t+XLEN+1.
  - done=1 and new hi/lo visible in cycle t+XLEN+2 (34 cycles after issue for XLEN=32).
  - Divide-by-zero path: busy in t+1 only, done/div_by_zero in t+2.
- Results:
  - MULT/MULTU: {hi,lo} = 2·XLEN product.
  - DIV/DIVU: lo=quotient, hi=remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
  - DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
  - Divide by zero: lo=all ones, hi=dividend (raw latched value), div_by_zero=1.
- start while busy: ignored, no effect on the in-flight op. stall_req stays 1 via busy.
- flush in any non-IDLE state: next edge → IDLE. No done; hi/lo unchanged. flush together with start in IDLE: start is not accepted.
- hi_we/lo_we:
  - Write mt_data on the edge when state is IDLE or CALC (CALC writes are overwritten at FIN).
  - In FIN, the MD result wins over hi_we/lo_we.
  - Independent of start.
- done and div_by_zero are registered single-cycle pulses. No back-to-back merge: a new start in the done cycle is accepted normally.

Test Plan:
- MULTU, busA=0xFFFFFFFF, busB=2, sel=10/10, start at t → busy t+1..t+33; done at t+34 with hi=0x00000001, lo=0xFFFFFFFE.
- MULT, fwd_exmem_a=0xFFFFFFFD (-3), srcA_sel=01, busB=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Confirms forwarding mux selection.
- DIV, -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, 7 / 2 → lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU, 100 / 0 → done at t+2, div_by_zero=1, lo=0xFFFFFFFF, hi=100.
- MULTU started, flush asserted in cycle t+10 → busy=0 from t+11, no done ever, hi/lo equal to pre-op values. A second start during CALC → ignored (result matches the first op only).
- rst asserted mid-CALC → next cycle hi=lo=0, busy=0; hi_we with mt_data=0x1234 while IDLE → hi=0x1234 next cycle, lo unchanged.
